corr_readout: RTL and testbench



---
 rtl/corr_pkg.sv | 29 ++
 rtl/corr_readout_if.sv | 29 ++
 rtl/corr_word_mux.sv | 29 ++
 rtl/corr_readout.sv | 147 ++++++++++++++
 tb/tb_corr_readout.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/corr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : corr_pkg
// Brief    : Shared encodings and constants for the correlation readout.
// Revision : 1.0
// ============================================================================
package corr_pkg;

    localparam int NSUMS  = 6;
    localparam int NWORDS = 12;
    localparam int IDX_W  = 4;
    localparam int CNT_W  = 16;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    // Header layout: {sync[31:24], 7'd0, ovr_sticky[16], frame_cnt[15:0]}
    localparam int HDR_SYNC_LSB = 24;
    localparam int HDR_OVR_BIT  = 16;
    localparam int HDR_CNT_LSB  = 0;

    localparam int STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/corr_readout_if.sv
`default_nettype none
// ============================================================================
// Module   : corr_readout_if
// Brief    : Valid/ready word stream from the readout toward the host link.
// Revision : 1.0
// ============================================================================
interface corr_readout_if #(
    parameter int WORD = 32
);
    logic [WORD-1:0] out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/corr_word_mux.sv
`default_nettype none
// ============================================================================
// Module   : corr_word_mux
// Brief    : Selects data word idx from the snapshot, high half of each sum first.
// Revision : 1.0
// ============================================================================
module corr_word_mux
    import corr_pkg::*;
#(
    parameter int DIM_OUT = 64,
    parameter int WORD    = 32
) (
    input  wire [NSUMS-1:0][DIM_OUT-1:0] snap,
    input  wire [IDX_W-1:0]              idx,
    output logic [WORD-1:0]              word
);

    logic [IDX_W-2:0] w_sel;

    always_comb begin
        word  = '0;
        w_sel = idx[IDX_W-1:1];
        if (idx < IDX_W'(NWORDS)) begin
            word = idx[0] ? snap[w_sel][WORD-1:0] : snap[w_sel][DIM_OUT-1:WORD];
        end
    end

endmodule
`default_nettype wire

// File: rtl/corr_readout.sv
`default_nettype none
// ============================================================================
// Module   : corr_readout
// Brief    : Snapshots six correlation sums on done and streams a 13-word frame.
// Revision : 1.0
// ============================================================================
module corr_readout
    import corr_pkg::*;
#(
    parameter int         DIM_OUT = 64,
    parameter int         WORD    = 32,
    parameter logic [7:0] SYNC    = SYNC_DEFAULT
) (
    input  wire                clk,
    input  wire                clr,
    input  wire                done,
    input  wire [DIM_OUT-1:0]  sum_x_2,
    input  wire [DIM_OUT-1:0]  sum_xy,
    input  wire [DIM_OUT-1:0]  sum_y_2,
    input  wire [DIM_OUT-1:0]  sum_xy90,
    input  wire [DIM_OUT-1:0]  sum_y90_2,
    input  wire [DIM_OUT-1:0]  sum_y_y90,
    output logic               acc_clr,
    output logic               busy,
    output logic               overrun,
    corr_readout_if.master     bus
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NWORDS - 1);

    state_t                       r_state;
    state_t                       w_next_state;
    logic [NSUMS-1:0][DIM_OUT-1:0] r_snap;
    logic [NSUMS-1:0][DIM_OUT-1:0] w_sums;
    logic [IDX_W-1:0]             r_idx;
    logic [CNT_W-1:0]             r_frame_cnt;
    logic                         r_ovr_sticky;
    logic                         r_acc_clr;
    logic                         r_overrun;

    logic [WORD-1:0]              w_header;
    logic [WORD-1:0]              w_mux_word;
    logic [WORD-1:0]              w_data;
    logic                         w_valid;
    logic                         w_last;
    logic                         w_hdr_accept;
    logic                         w_data_accept;
    logic                         w_last_accept;
    logic                         w_capture;
    logic                         w_drop;

    // Index 0 is sum_x_2 so the word mux walks the sums in stream order.
    assign w_sums = {sum_y_y90, sum_y90_2, sum_xy90, sum_y_2, sum_xy, sum_x_2};

    corr_word_mux #(
        .DIM_OUT (DIM_OUT),
        .WORD    (WORD)
    ) u_word_mux (
        .snap (r_snap),
        .idx  (r_idx),
        .word (w_mux_word)
    );

    always_comb begin
        w_header                              = '0;
        w_header[HDR_SYNC_LSB +: 8]           = SYNC;
        w_header[HDR_OVR_BIT]                 = r_ovr_sticky;
        w_header[HDR_CNT_LSB +: CNT_W]        = r_frame_cnt;
    end

    assign w_hdr_accept  = (r_state == ST_HDR)  & bus.out_ready;
    assign w_data_accept = (r_state == ST_DATA) & bus.out_ready;
    assign w_last_accept = w_data_accept & (r_idx == c_last_idx);
    // A done landing on the final accept starts the next frame with no idle gap.
    assign w_capture     = done & ((r_state == ST_IDLE) | w_last_accept);
    assign w_drop        = done & ~w_capture;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_valid      = 1'b0;
        w_last       = 1'b0;
        w_data       = '0;
        case (r_state)
            ST_IDLE: begin
                if (done) w_next_state = ST_HDR;
            end
            ST_HDR: begin
                w_valid = 1'b1;
                w_data  = w_header;
                if (bus.out_ready) w_next_state = ST_DATA;
            end
            ST_DATA: begin
                w_valid = 1'b1;
                w_data  = w_mux_word;
                w_last  = (r_idx == c_last_idx);
                if (bus.out_ready && w_last) w_next_state = done ? ST_HDR : ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_snap       <= '0;
            r_idx        <= '0;
            r_frame_cnt  <= '0;
            r_ovr_sticky <= 1'b0;
            r_acc_clr    <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_acc_clr <= w_capture;
            r_overrun <= w_drop;
            if (w_capture) begin
                r_snap <= w_sums;
            end
            if (w_hdr_accept) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
                r_idx       <= '0;
            end else if (w_data_accept) begin
                r_idx <= r_idx + 1'b1;
            end
            // A drop on the same cycle as the header accept must stay visible.
            if (w_drop) begin
                r_ovr_sticky <= 1'b1;
            end else if (w_hdr_accept) begin
                r_ovr_sticky <= 1'b0;
            end
        end
    end

    assign acc_clr       = r_acc_clr;
    assign overrun       = r_overrun;
    assign busy          = (r_state != ST_IDLE);
    assign bus.out_valid = w_valid;
    assign bus.out_last  = w_last;
    assign bus.out_data  = w_data;

endmodule
`default_nettype wire

// File: tb/tb_corr_readout.sv
`default_nettype none
// ============================================================================
// Module   : tb_corr_readout
// Brief    : Scoreboard bench for corr_readout frame streaming.
// Revision : 1.0
// ============================================================================
module tb_corr_readout;

    logic        clk = 1'b0;
    logic        clr;
    logic        done;
    logic [63:0] sums [6];
    logic        acc_clr;
    logic        busy;
    logic        overrun;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [32:0] sb [$];
    logic [32:0] exp_w;
    logic [15:0] m_cnt;
    logic        m_sticky;

    corr_readout_if #(.WORD(32)) bus ();

    corr_readout #(
        .DIM_OUT (64),
        .WORD    (32),
        .SYNC    (8'hA5)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .done      (done),
        .sum_x_2   (sums[0]),
        .sum_xy    (sums[1]),
        .sum_y_2   (sums[2]),
        .sum_xy90  (sums[3]),
        .sum_y90_2 (sums[4]),
        .sum_y_y90 (sums[5]),
        .acc_clr   (acc_clr),
        .busy      (busy),
        .overrun   (overrun),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic rdy, input logic dn);
        @(negedge clk);
        bus.out_ready = rdy;
        done          = dn;
    endtask

    task automatic set_sums(input logic [31:0] base);
        for (int i = 0; i < 6; i++) begin
            sums[i] = {base + 32'(2 * i), base + 32'(2 * i + 1)};
        end
    endtask

    // Reference model: header then each sum high word, low word.
    function automatic void push_frame();
        logic [63:0] s;
        sb.push_back({1'b0, 8'hA5, 7'd0, m_sticky, m_cnt});
        for (int i = 0; i < 12; i++) begin
            s = sums[i / 2];
            sb.push_back({(i == 11), (i % 2 == 0) ? s[63:32] : s[31:0]});
        end
        m_cnt    = m_cnt + 16'd1;
        m_sticky = 1'b0;
    endfunction

    task automatic test_reset();
        clr = 1'b1;
        done = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.out_valid, busy, acc_clr, overrun, bus.out_last} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected %b",
                     {bus.out_valid, busy, acc_clr, overrun, bus.out_last}, 5'b0);
        end
        n_cmp++;
        if (bus.out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected %h", bus.out_data, 32'h0);
        end
        clr  = 1'b0;
        done = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.out_valid, busy, acc_clr} !== 3'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got %b expected %b", {bus.out_valid, busy, acc_clr}, 3'b0);
        end
        m_cnt    = 16'd0;
        m_sticky = 1'b0;
        sb.delete();
    endtask

    task automatic test_basic();
        set_sums(32'd1);
        repeat (7) drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        push_frame();
        for (int k = 0; k < 13; k++) begin
            drive(1'b1, 1'b0);
            n_cmp++;
            if (acc_clr !== (k == 0)) begin
                n_fail++;
                $display("FAIL basic_acc_clr k=%0d: got %b expected %b", k, acc_clr, (k == 0));
            end
            n_cmp++;
            if ({bus.out_valid, busy} !== 2'b11) begin
                n_fail++;
                $display("FAIL basic_valid k=%0d: got %b expected 11", k, {bus.out_valid, busy});
            end
            if (bus.out_valid && bus.out_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL basic_word: got extra %h expected none", bus.out_data);
                end else begin
                    exp_w = sb.pop_front();
                    if ({bus.out_last, bus.out_data} !== exp_w) begin
                        n_fail++;
                        $display("FAIL basic_word k=%0d: got %h expected %h", k, {bus.out_last, bus.out_data}, exp_w);
                    end
                end
            end
        end
        drive(1'b1, 1'b0);
        n_cmp++;
        if ({bus.out_valid, busy, acc_clr} !== 3'b0) begin
            n_fail++;
            $display("FAIL basic_idle: got %b expected 000", {bus.out_valid, busy, acc_clr});
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL basic_drained: got %0d left expected 0", sb.size());
        end
    endtask

    task automatic test_backpressure();
        int          got;
        int          stall;
        logic        toggle;
        logic        rdy;
        logic        prev_hold;
        logic [32:0] prev_word;
        for (int i = 0; i < 6; i++) sums[i] = {$urandom(), $urandom()};
        drive(1'b0, 1'b1);
        push_frame();
        got = 0; stall = 0; toggle = 1'b1; prev_hold = 1'b0; prev_word = '0;
        for (int c = 0; c < 200 && sb.size() != 0; c++) begin
            if (got == 6 && stall < 5) begin
                rdy = 1'b0;
                stall++;
            end else begin
                rdy = toggle;
                toggle = ~toggle;
            end
            drive(rdy, 1'b0);
            if (prev_hold) begin
                n_cmp++;
                if ({bus.out_last, bus.out_data} !== prev_word) begin
                    n_fail++;
                    $display("FAIL bp_hold c=%0d: got %h expected %h", c, {bus.out_last, bus.out_data}, prev_word);
                end
            end
            n_cmp++;
            if (bus.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_valid c=%0d: got %b expected 1", c, bus.out_valid);
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_word = {bus.out_last, bus.out_data};
            if (bus.out_valid && bus.out_ready) begin
                exp_w = sb.pop_front();
                got++;
                n_cmp++;
                if ({bus.out_last, bus.out_data} !== exp_w) begin
                    n_fail++;
                    $display("FAIL bp_word %0d: got %h expected %h", got, {bus.out_last, bus.out_data}, exp_w);
                end
            end
        end
        n_cmp++;
        if (sb.size() != 0 || stall != 5) begin
            n_fail++;
            $display("FAIL bp_timeout: got %0d left stall %0d expected 0 left stall 5", sb.size(), stall);
        end
    endtask

    task automatic test_overrun();
        int   got;
        int   n_ovr;
        logic dn;
        logic prev_dn;
        set_sums(32'h200);
        drive(1'b1, 1'b1);
        push_frame();
        got = 0; n_ovr = 0; prev_dn = 1'b0;
        for (int c = 0; c < 40 && sb.size() != 0; c++) begin
            dn = (got == 5);
            if (dn) begin
                set_sums(32'h900);
                m_sticky = 1'b1;
            end
            drive(1'b1, dn);
            if (prev_dn) begin
                n_cmp++;
                if ({overrun, acc_clr} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL ovr_pulse: got ovr/acc_clr %b expected 10", {overrun, acc_clr});
                end
            end
            if (overrun === 1'b1) n_ovr++;
            if (bus.out_valid && bus.out_ready) begin
                exp_w = sb.pop_front();
                got++;
                n_cmp++;
                if ({bus.out_last, bus.out_data} !== exp_w) begin
                    n_fail++;
                    $display("FAIL ovr_word %0d: got %h expected %h", got, {bus.out_last, bus.out_data}, exp_w);
                end
            end
            prev_dn = dn;
        end
        drive(1'b1, 1'b0);
        if (overrun === 1'b1) n_ovr++;
        n_cmp++;
        if (n_ovr != 1 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL ovr_count: got %0d pulses %0d left expected 1 pulses 0 left", n_ovr, sb.size());
        end
    endtask

    task automatic test_boundary();
        int   got;
        int   n_ovr;
        logic dn;
        logic prev_dn;
        logic second;
        set_sums(32'h300);
        drive(1'b1, 1'b1);
        push_frame();
        got = 0; n_ovr = 0; prev_dn = 1'b0; second = 1'b0;
        for (int c = 0; c < 60 && sb.size() != 0; c++) begin
            dn = (got == 12) && !second;
            if (dn) begin
                set_sums(32'h400);
                push_frame();
                second = 1'b1;
            end
            drive(1'b1, dn);
            if (prev_dn) begin
                n_cmp++;
                if ({acc_clr, bus.out_valid, busy} !== 3'b111) begin
                    n_fail++;
                    $display("FAIL bnd_restart: got %b expected 111", {acc_clr, bus.out_valid, busy});
                end
            end
            if (overrun === 1'b1) n_ovr++;
            if (bus.out_valid && bus.out_ready) begin
                exp_w = sb.pop_front();
                got++;
                n_cmp++;
                if ({bus.out_last, bus.out_data} !== exp_w) begin
                    n_fail++;
                    $display("FAIL bnd_word %0d: got %h expected %h", got, {bus.out_last, bus.out_data}, exp_w);
                end
            end
            prev_dn = dn;
        end
        n_cmp++;
        if (n_ovr != 0 || sb.size() != 0 || !second) begin
            n_fail++;
            $display("FAIL bnd_end: got %0d pulses %0d left expected 0 pulses 0 left", n_ovr, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        int got;
        set_sums(32'h500);
        drive(1'b1, 1'b1);
        push_frame();
        got = 0;
        for (int c = 0; c < 30 && got < 7; c++) begin
            drive(1'b1, 1'b0);
            if (bus.out_valid && bus.out_ready) begin
                exp_w = sb.pop_front();
                got++;
                n_cmp++;
                if ({bus.out_last, bus.out_data} !== exp_w) begin
                    n_fail++;
                    $display("FAIL rstmid_word %0d: got %h expected %h", got, {bus.out_last, bus.out_data}, exp_w);
                end
            end
        end
        @(negedge clk);
        clr = 1'b1;
        done = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        done = 1'b0;
        n_cmp++;
        if ({bus.out_valid, busy, acc_clr, overrun} !== 4'b0 || got != 7) begin
            n_fail++;
            $display("FAIL rstmid_idle: got %b after %0d words expected 0000 after 7",
                     {bus.out_valid, busy, acc_clr, overrun}, got);
        end
        sb.delete();
        m_cnt    = 16'd0;
        m_sticky = 1'b0;
        drive(1'b1, 1'b1);
        push_frame();
        for (int c = 0; c < 40 && sb.size() != 0; c++) begin
            drive(1'b1, 1'b0);
            if (bus.out_valid && bus.out_ready) begin
                exp_w = sb.pop_front();
                n_cmp++;
                if ({bus.out_last, bus.out_data} !== exp_w) begin
                    n_fail++;
                    $display("FAIL rstmid_frame: got %h expected %h", {bus.out_last, bus.out_data}, exp_w);
                end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL rstmid_timeout: got %0d left expected 0", sb.size());
        end
    endtask

    task automatic test_wrap();
        force dut.r_frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_frame_cnt;
        m_cnt = 16'hFFFF;
        for (int f = 0; f < 2; f++) begin
            set_sums(32'h600 + 32'(f * 32));
            drive(1'b1, 1'b1);
            push_frame();
            for (int c = 0; c < 40 && sb.size() != 0; c++) begin
                drive(1'b1, 1'b0);
                if (bus.out_valid && bus.out_ready) begin
                    exp_w = sb.pop_front();
                    n_cmp++;
                    if ({bus.out_last, bus.out_data} !== exp_w) begin
                        n_fail++;
                        $display("FAIL wrap_word f=%0d: got %h expected %h", f, {bus.out_last, bus.out_data}, exp_w);
                    end
                end
            end
            n_cmp++;
            if (sb.size() != 0) begin
                n_fail++;
                $display("FAIL wrap_timeout f=%0d: got %0d left expected 0", f, sb.size());
            end
        end
    endtask

    initial begin
        clr = 1'b1;
        done = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) sums[i] = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_overrun();
        test_boundary();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
